// File: rtl/led_driver.sv
// Status LED driver: off/on/blink/dim modes with an activity stretch that forces the LED lit.
// Build option: define LED_DRIVER_PWM_EN to compile in the dim (PWM) mode; otherwise dim behaves as steady on.
module led_driver #(
  parameter int CLK_DIV       = 16,
  parameter int BLINK_TICKS   = 8,
  parameter int STRETCH_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] MODE,
  input  logic [3:0] DUTY,
  input  logic       ACT,
  output logic       _LED,
  output logic       STRETCHING
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int SW = $clog2(STRETCH_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] STRETCH_LD  = SW'(STRETCH_TICKS);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_DIM   = 2'd3;

  logic [PW-1:0] presc_q, presc_n;
  logic          tick_q, tick_n;
  logic [1:0]    mode_q, mode_n;
  logic [BW-1:0] blink_cnt_q, blink_cnt_n;
  logic          phase_q, phase_n;
  logic [SW-1:0] stretch_q, stretch_n;
  logic          led_n, stretching_n;
  logic          lit;

`ifdef LED_DRIVER_PWM_EN
  logic [3:0]    pwm_q, pwm_n;
`else
  logic          unused_duty;
  assign unused_duty = ^DUTY;
`endif

  always_comb begin
    presc_n      = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    tick_n       = (presc_q == PRESC_MAX);
    mode_n       = MODE;
    blink_cnt_n  = blink_cnt_q;
    phase_n      = phase_q;
    stretch_n    = stretch_q;
    lit          = 1'b0;

    // Entering blink restarts a full lit half-period; otherwise the blink counter runs freely.
    if (MODE == MODE_BLINK && mode_q != MODE_BLINK) begin
      phase_n     = 1'b1;
      blink_cnt_n = '0;
    end else if (tick_q) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_n = '0;
        phase_n     = ~phase_q;
      end else begin
        blink_cnt_n = blink_cnt_q + BW'(1);
      end
    end

    if (ACT) begin
      stretch_n = STRETCH_LD;
    end else if (tick_q && stretch_q != '0) begin
      stretch_n = stretch_q - SW'(1);
    end

`ifdef LED_DRIVER_PWM_EN
    pwm_n = pwm_q + 4'd1;
`endif

    case (MODE)
      MODE_OFF:   lit = 1'b0;
      MODE_ON:    lit = 1'b1;
      MODE_BLINK: lit = phase_n;
`ifdef LED_DRIVER_PWM_EN
      MODE_DIM:   lit = (pwm_q < DUTY);
`else
      MODE_DIM:   lit = 1'b1;
`endif
      default:    lit = 1'b0;
    endcase

    stretching_n = (stretch_n != '0);
    if (stretching_n) lit = 1'b1;
    led_n = ~lit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      stretch_q   <= '0;
      _LED        <= 1'b1;
      STRETCHING  <= 1'b0;
`ifdef LED_DRIVER_PWM_EN
      pwm_q       <= '0;
`endif
    end else begin
      presc_q     <= presc_n;
      tick_q      <= tick_n;
      mode_q      <= mode_n;
      blink_cnt_q <= blink_cnt_n;
      phase_q     <= phase_n;
      stretch_q   <= stretch_n;
      _LED        <= led_n;
      STRETCHING  <= stretching_n;
`ifdef LED_DRIVER_PWM_EN
      pwm_q       <= pwm_n;
`endif
    end
  end

endmodule

// File: doc/led_driver.md
LED_DRIVER -- requirements
Module: led_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clocks per prescaler tick (>=2).
REQ-002 SHALL have parameter BLINK_TICKS, default 8: ticks per blink half-period (>=1).
REQ-003 SHALL have parameter STRETCH_TICKS, default 4: ticks an activity pulse holds the LED lit (>=1).
REQ-004 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port MODE  input  2  0=off, 1=on, 2=blink, 3=dim.
REQ-007 SHALL have port DUTY  input  4  dim duty in sixteenths, sampled every clock.
REQ-008 SHALL have port ACT  input  1  activity strobe, active-high, any width.
REQ-009 SHALL have port _LED  output  1  LED drive, active-low (0 = lit), feeds an LED model directly.
REQ-010 SHALL have port STRETCHING  output  1  high while an activity stretch is in progress.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and wrap; the internal tick SHALL be asserted for exactly one clock on the wrap.
REQ-012 _LED and STRETCHING SHALL be registered; any input change SHALL be reflected one clock later.
REQ-013 MODE=0 SHALL drive _LED=1; MODE=1 SHALL drive _LED=0.
REQ-014 MODE=2 SHALL use a blink phase bit that toggles after every BLINK_TICKS ticks; phase 1 lights the LED.
REQ-015 Entering MODE=2 from any other mode SHALL set the phase to 1 and clear the blink tick counter, so the first lit half-period is full length.
REQ-016 MODE=3 SHALL use a 4-bit PWM counter incrementing every clock and wrapping 15->0; the LED SHALL be lit when counter < DUTY.
REQ-017 DUTY=0 SHALL keep the LED dark; DUTY=15 SHALL light it 15 of every 16 clocks.
REQ-018 ACT=1 on a clock SHALL load the stretch counter with STRETCH_TICKS; each tick with ACT=0 SHALL decrement it, stopping at 0.
REQ-019 ACT held high SHALL keep reloading, so the stretch expires STRETCH_TICKS ticks after the last ACT clock.
REQ-020 A nonzero stretch counter SHALL force the LED lit regardless of MODE, and STRETCHING SHALL be 1 exactly then.
REQ-021 ACT and a tick on the same clock SHALL reload with no decrement; the reload takes priority.
REQ-022 The prescaler, blink and PWM counters SHALL run freely regardless of MODE or ACT, except as REQ-015 specifies.

Reset
REQ-023 RST=1 SHALL, on the next clock edge, set _LED=1, STRETCHING=0, blink phase=0, and all counters to 0.
REQ-024 RST asserted mid-stretch or mid-blink SHALL abort the operation, and outputs SHALL stay at reset values while RST=1.
REQ-025 ACT is ignored while RST=1; after release, the first tick SHALL occur CLK_DIV clocks after the first non-reset edge.

Configuration
REQ-026 Macro LED_DRIVER_PWM_EN defined SHALL compile in the PWM counter and the REQ-016/017 dim behaviour.
REQ-027 With LED_DRIVER_PWM_EN undefined, MODE=3 SHALL behave as MODE=1 (steady lit), DUTY SHALL be ignored, and no PWM counter SHALL exist.

Verification
REQ-028 Reset, then MODE=1 -> _LED=1 during reset; _LED=0 one clock after RST falls.
REQ-029 Defaults, MODE=2 from MODE=0 -> _LED=0 for 128 clocks, then 1 for 128 clocks, repeating.
REQ-030 Defaults, MODE=0, one-clock ACT pulse -> _LED=0 and STRETCHING=1 next clock, both released on the 4th tick after the pulse.
REQ-031 With PWM_EN defined, MODE=3 and DUTY=0/4/15 -> 0, 4 and 15 lit clocks per 16-clock window respectively.
REQ-032 With PWM_EN undefined, MODE=3 and DUTY=4 -> _LED constantly 0.
REQ-033 Mid-stretch with MODE=2, assert RST for 1 clock -> _LED=1 and STRETCHING=0; after release, blink restarts lit.
